// File: rtl/tc_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tc_program_loader
// Brief    : Framed byte-stream loader that writes program memory at run time
//            and verifies a trailing modulo-256 payload checksum.
// Revision : 1.0
// ============================================================================
module tc_program_loader #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] count
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR_HI = 4'd1,
        S_ADDR_LO = 4'd2,
        S_LEN_HI  = 4'd3,
        S_LEN_LO  = 4'd4,
        S_DATA    = 4'd5,
        S_CSUM    = 4'd6,
        S_DONE    = 4'd7,
        S_ERROR   = 4'd8
    } state_t;

    localparam logic [16:0] c_mem_limit = 17'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [15:0] start_addr_q, start_addr_d;
    logic [15:0] len_q, len_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  sum_q, sum_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        w_xfer;
    logic [15:0] w_len_full;
    logic [16:0] w_frame_end;
    logic [15:0] w_count_inc;

    assign w_xfer      = in_valid && active_q;
    assign w_len_full  = {len_q[15:8], in_data};
    // 17-bit end address so a frame reaching past 0xFFFF cannot wrap into range
    assign w_frame_end = {1'b0, start_addr_q} + {1'b0, w_len_full};
    assign w_count_inc = count_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        len_d        = len_q;
        count_d      = count_q;
        sum_d        = sum_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_ADDR_HI;
                    count_d = 16'd0;
                    sum_d   = 8'd0;
                end
            end
            S_ADDR_HI: begin
                if (w_xfer) begin
                    start_addr_d = {in_data, start_addr_q[7:0]};
                    state_d      = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (w_xfer) begin
                    start_addr_d = {start_addr_q[15:8], in_data};
                    state_d      = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    len_d   = {in_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    len_d = w_len_full;
                    if (w_frame_end > c_mem_limit) begin
                        state_d = S_ERROR;
                    end else if (w_len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = start_addr_q + count_q;
                    mem_wdata_d = in_data;
                    sum_d       = sum_q + in_data;
                    count_d     = w_count_inc;
                    if (w_count_inc == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they are registered
        active_d = state_d inside {S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
        done_d   = (state_d == S_DONE);
        error_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_addr_q <= 16'd0;
            len_q        <= 16'd0;
            count_q      <= 16'd0;
            sum_q        <= 8'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'd0;
            mem_wdata_q  <= 8'd0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            len_q        <= len_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            active_q     <= active_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready  = active_q;
    assign busy      = active_q;
    assign done      = done_q;
    assign error     = error_q;
    assign count     = count_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_tc_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_program_loader
// Brief    : Directed frames against a frame-index model of the loader.
// Revision : 1.0
// ============================================================================
module tb_tc_program_loader;

    localparam int MEM_BYTES = 256;

    typedef logic [7:0]  bq_t[$];
    typedef logic [23:0] wq_t[$];
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, busy, done, error;
    logic [15:0] mem_addr, count;
    logic [7:0]  mem_wdata;

    always #5 clk = ~clk;

    tc_program_loader #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .count(count)
    );

    // Expected outputs for the current cycle
    logic        e_busy, e_done, e_error, e_we;
    logic [15:0] e_addr, e_count;
    logic [7:0]  e_wdata;
    // Frame progress: bytes received, decoded header, running payload sum
    int          m_idx, m_addr, m_len;
    logic [31:0] m_hdr;
    logic [7:0]  m_sum;

    bit  chk_en = 1'b0;
    int  n_pass = 0;
    int  n_chk  = 0;
    wr_t wr_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(e_busy));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("error", 32'(error), 32'(e_error));
            check("count", 32'(count), 32'(e_count));
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            if (mem_we) wr_log.push_back('{mem_addr, mem_wdata});
        end
    end

    task automatic model_edge(input bit v, input logic [7:0] d, input bit st, input bit r);
        e_we = 1'b0;
        if (r) begin
            e_busy = 0; e_done = 0; e_error = 0;
            e_count = 16'd0; e_addr = 16'd0; e_wdata = 8'd0;
        end else if (!e_busy) begin
            if (st) begin
                e_busy = 1; e_done = 0; e_error = 0; e_count = 16'd0;
                m_idx = 0; m_sum = 8'd0; m_hdr = 32'd0;
            end
        end else if (v) begin
            if (m_idx < 4) begin
                m_hdr = {m_hdr[23:0], d};
                m_idx++;
                if (m_idx == 4) begin
                    m_addr = int'(m_hdr[31:16]);
                    m_len  = int'(m_hdr[15:0]);
                    if (m_addr + m_len > MEM_BYTES) begin
                        e_busy = 0; e_error = 1;
                    end
                end
            end else if (m_idx - 4 < m_len) begin
                e_we    = 1'b1;
                e_addr  = 16'(m_addr + m_idx - 4);
                e_wdata = d;
                m_sum   = m_sum + d;
                e_count = e_count + 16'd1;
                m_idx++;
            end else begin
                e_busy = 0;
                if (d == m_sum) e_done = 1;
                else e_error = 1;
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit st, input bit r);
        in_valid = v; in_data = d; start = st; rst = r;
        @(posedge clk);
        #1;
        model_edge(v, d, st, r);
    endtask

    task automatic frame(input bq_t b, input bit stalls, input int ign);
        wr_log.delete();
        step(0, 8'h00, 1, 0);
        foreach (b[i]) begin
            if (stalls) repeat ($urandom_range(0, 2)) step(0, 8'($urandom), 0, 0);
            step(1, b[i], (i == ign), 0);
        end
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
    endtask

    task automatic chk_writes(input string name, input wq_t exp);
        check({name, "_n"}, 32'(wr_log.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            check(name, (i < wr_log.size()) ? {8'h00, wr_log[i].a, wr_log[i].d} : 32'hDEADBEEF,
                  {8'h00, exp[i]});
        end
    endtask

    initial begin
        bq_t f;
        e_busy = 0; e_done = 0; e_error = 0; e_we = 0;
        e_addr = 0; e_count = 0; e_wdata = 0;
        m_idx = 0; m_addr = 0; m_len = 0; m_hdr = 0; m_sum = 0;
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 1, 1);
        chk_en = 1'b1;
        step(0, 8'h00, 0, 0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);

        // Nominal load
        f = {8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        frame(f, 0, -1);
        chk_writes("nom_wr", {24'h0010AA, 24'h0011BB, 24'h0012CC});
        check("nom_done", 32'(done), 32'd1);
        check("nom_error", 32'(error), 32'd0);
        check("nom_count", 32'(count), 32'd3);

        // Zero length, good then bad checksum
        f = {8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        frame(f, 0, -1);
        check("zl_nwr", 32'(wr_log.size()), 32'd0);
        check("zl_done", 32'(done), 32'd1);
        f = {8'h00, 8'h05, 8'h00, 8'h00, 8'h01};
        frame(f, 0, -1);
        check("zl_bad_error", 32'(error), 32'd1);

        // Checksum mismatch keeps the written bytes
        f = {8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h04};
        frame(f, 0, -1);
        chk_writes("cs_wr", {24'h000001, 24'h000102});
        check("cs_error", 32'(error), 32'd1);
        check("cs_done", 32'(done), 32'd0);
        check("cs_ready", 32'(in_ready), 32'd0);

        // Range reject, then the last legal placement
        f = {8'h00, 8'hFF, 8'h00, 8'h02};
        frame(f, 0, -1);
        check("rng_nwr", 32'(wr_log.size()), 32'd0);
        check("rng_error", 32'(error), 32'd1);
        f = {8'h00, 8'hFE, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        frame(f, 0, -1);
        chk_writes("edge_wr", {24'h00FE11, 24'h00FF22});
        check("edge_done", 32'(done), 32'd1);

        // Stalls, and a start pulse mid-frame that must be ignored
        f = {8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        frame(f, 1, -1);
        chk_writes("stall_wr", {24'h0010AA, 24'h0011BB, 24'h0012CC});
        frame(f, 1, 5);
        chk_writes("ign_wr", {24'h0010AA, 24'h0011BB, 24'h0012CC});
        check("ign_done", 32'(done), 32'd1);

        // Reset mid-frame after the second payload byte (rst beats start)
        step(0, 8'h00, 1, 0);
        f = {8'h00, 8'h20, 8'h00, 8'h05, 8'h01, 8'h02};
        foreach (f[i]) step(1, f[i], 0, 0);
        step(1, 8'h03, 1, 1);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_addr", 32'(mem_addr), 32'd0);
        f = {8'h00, 8'h20, 8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F};
        frame(f, 0, -1);
        check("mrst_done", 32'(done), 32'd1);
        check("mrst_cnt5", 32'(count), 32'd5);

        step(0, 8'h00, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tc_program_loader.md
# tc_program_loader

Write-side counterpart of the program ROM read port. It accepts a framed byte stream over a valid/ready handshake, decodes a start-address/length header, and drives one-byte write strobes into program memory. It verifies a trailing checksum and reports done or error. It sits between a host/debug byte source and the program memory write port, so program memory can be loaded at run time instead of only from a hex file.

## Interface
- MEM_BYTES, 256: writable program memory size in bytes; frames reaching beyond it are rejected.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that arms the loader for a new frame.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle write strobe to program memory.
- mem_addr  output  16  write address.
- mem_wdata  output  8  write data.
- busy  output  1  a frame is in progress (states ADDR_HI..CSUM).
- done  output  1  last frame completed with a good checksum; sticky until start or rst.
- error  output  1  last frame failed (range or checksum); sticky until start or rst.
- count  output  16  payload bytes written in the current or last frame.

## Operation
- Frame byte order: ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN payload bytes, CSUM.
- CSUM must equal the 8-bit modulo-256 sum of the payload bytes only; for LEN=0 it must be 0x00.
- A byte transfers only in a cycle where in_valid && in_ready.
- States and transitions:
  - IDLE: start goes to ADDR_HI.
  - ADDR_HI: advances to ADDR_LO on a transfer.
  - ADDR_LO: advances to LEN_HI on a transfer.
  - LEN_HI: advances to LEN_LO on a transfer.
  - LEN_LO: advances on a transfer to ERROR if start_addr + LEN > MEM_BYTES (17-bit compare); else to CSUM if LEN = 0; else to DATA.
  - DATA: each transfer writes one byte. The last byte (count reaching LEN) moves to CSUM.
  - CSUM: a transfer with a match goes to DONE; a mismatch goes to ERROR.
  - DONE / ERROR: start goes to ADDR_HI. Any other input keeps the state.
- in_ready = 1 exactly in ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA and CSUM; 0 in IDLE, DONE and ERROR.
- A start pulse while busy is ignored. It does not restart, clear or change any state.
- Starting a frame clears done, error, count and the running sum.
- Payload byte i (0-based) is written to mem_addr = start_addr + i, truncated to 16 bits. The range check prevents wrap for legal frames.
- Running sum is 8 bits and wraps modulo 256.
- count increments by 1 per payload byte written and saturates at LEN. It holds its value in DONE and ERROR.
- Payload bytes already written before an error stay in memory. The loader never rolls back.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, count=0, state=IDLE.
- start sampled at edge N gives in_ready=1 and busy=1 from cycle N+1.
- Write latency is 1 cycle. A payload transfer at edge N gives mem_we=1, mem_addr and mem_wdata valid during cycle N+1, for exactly one cycle.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Back-to-back transfers give back-to-back mem_we with no bubble.
- Gaps in in_valid stall the FSM with no state change.
- A CSUM transfer at edge N gives done or error =1 and busy=0 during cycle N+1.
- The write strobe for the last payload byte may coincide with the CSUM transfer cycle.
- A range error from the LEN_LO transfer at edge N gives error=1 and in_ready=0 during cycle N+1. No mem_we is ever issued for that frame.
- rst has priority over all inputs, including start in the same cycle. Reset mid-frame returns to IDLE with the reset values above; a pending mem_we is dropped.

## Test plan
- Nominal load: start, then bytes 00 10 00 03 AA BB CC 31 -> writes AA@0x0010, BB@0x0011, CC@0x0012 on consecutive cycles; done=1, error=0, count=3.
- Zero length: start, then 00 05 00 00 00 -> no mem_we; done=1, count=0. The same frame with CSUM=01 -> error=1.
- Checksum mismatch: start, then 00 00 00 02 01 02 04 -> both bytes written at 0x0000/0x0001, then error=1, done=0, in_ready=0.
- Range reject with MEM_BYTES=256: start, then 00 FF 00 02 -> error=1 right after the LEN_LO transfer, no mem_we. Start 00 FE with len 2 is accepted and ends with done=1.
- Backpressure and stalls: the nominal frame with in_valid toggling randomly -> an identical write sequence and result. A start pulse mid-frame is ignored: count keeps rising and the frame completes.
- Reset mid-frame: rst asserted after the 2nd payload byte of a 5-byte frame -> all outputs return to reset values the next cycle. A subsequent start and full frame complete with done=1.
